submax_row_streamer: RTL
========================

Name: submax_row_streamer

Overview:
- Hardware reader for the submax Y-matrix read port (re/tq/tk in; rdata/rvalid back).
- After a start pulse it sweeps Y in raster order, row tq then column tk.
- Emits each element on a valid/ready stream with row/column tags and last flags.
- Sits between attention_presoft_submax_top and the downstream exp/softmax stage; replaces the software sweep done today from the bench.

Parameters:
- T, 4, max sequence length (Y is T×T)
- DATA_W, 32, element width (FP32 bits)
- T_W, $clog2(T) (1 if T<=1), index width
- FIFO_D, 4, output buffer depth; also the cap on outstanding reads (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle start pulse
- n_len  in  T_W+1  active matrix size N; clamped to T when N>T
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the final element has been accepted downstream
- y_re  out  1  read request to the Y port
- y_tq  out  T_W  read row index
- y_tk  out  T_W  read column index
- y_rdata  in  DATA_W  read data
- y_rvalid  in  1  read data valid; responses return in request order with latency >=1
- o_valid  out  1  stream valid
- o_ready  in  1  stream ready
- o_data  out  DATA_W  element Y[tq][tk]
- o_tq  out  T_W  element row
- o_tk  out  T_W  element column
- o_last_col  out  1  element is tk==N-1
- o_last  out  1  element is tq==N-1 and tk==N-1

Behaviour:
- Reset values:
  - busy, done, y_re, o_valid = 0.
  - y_tq, y_tk, o_data, o_tq, o_tk, o_last_col, o_last = 0.
  - FIFO empty, outstanding count = 0, state IDLE.
- States and transitions:
  - IDLE: start=1 latches N=min(n_len,T). If N=0, go to FIN; otherwise go to ISSUE and set busy=1.
  - ISSUE:
    - Assert y_re (one-cycle request) when outstanding+fifo_count < FIFO_D.
    - Index counters advance tk first; tk wraps to 0 and tq increments at N-1.
    - The request for (N-1,N-1) moves the state to DRAIN.
  - DRAIN: wait until outstanding==0 and the FIFO is empty with the last beat accepted, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Request rules:
  - y_tq/y_tk are valid only while y_re=1.
  - y_re is never high for more than N*N cycles per run.
  - At most FIFO_D requests are outstanding, so no response can be dropped.
- Responses:
  - Each y_rvalid pushes {y_rdata, tags} into the FIFO.
  - Tags come from separate return-side counters that mirror the request ordering.
  - The FIFO is never full when rvalid arrives; this is guaranteed by the credit rule.
- Stream:
  - o_* is driven from the FIFO head; o_valid = !empty.
  - A pop happens on o_valid&o_ready.
  - Payload is held stable while o_valid&!o_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - First-word latency is request latency + 1 cycle (registered FIFO output).
- Throughput: 1 element/cycle when o_ready is tied high and read latency <= FIFO_D-1.
- start while busy is ignored; the run in progress is unaffected.
- y_rvalid in IDLE or FIN is ignored (not pushed).
- rst mid-run:
  - Next cycle all state is at reset values.
  - The FIFO is flushed.
  - Late rvalids are ignored because the state is IDLE.
- Ordering: index counters are N-bounded; indices >= N are never issued.

Optional Feature:
- Macro: SUBMAX_ROW_STREAMER_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit, reset 0, sticky until next accepted start).
  - Per row, on each accepted beat:
    - Flag if the element is >0 by FP32 order; -0 and +0 both count as zero.
    - Track whether any element is +0 or -0; at o_last_col, flag if none was.
  - chk_err=1 from the cycle after the offending beat.
- When undefined:
  - No chk_err port.
  - No comparison logic.
  - Otherwise identical.

Test Plan:
- Y preloaded with Y[tq][tk]=32'h3F800000*(tq*4+tk)-style unique tags, N=4, o_ready=1, latency 1 -> 16 beats on 16 consecutive cycles in order (0,0)..(3,3); o_last_col on tk=3; o_last only on (3,3); done pulses 1 cycle after last beat; busy low after.
- Same data with o_ready toggling 1,0,0,1 repeating -> identical beat sequence; payload stable across stalls; outstanding+count never > 4; no lost or duplicated elements.
- Read latency 3 cycles with o_ready=1 -> 16 beats, in order; y_re throttled so at most 4 are outstanding.
- n_len=0 -> done one cycle after start, no y_re; n_len=6 with T=4 -> clamped, exactly 16 reads.
- rst asserted after the 5th beat, with rvalids still in flight, then start again with N=2 -> first run aborted, stale rvalids not emitted, second run emits exactly 4 beats (0,0),(0,1),(1,0),(1,1).
- With CHECK_EN: row 1 = {BF800000, 00000000, C0000000, BF000000}, others valid -> chk_err=0; change Y[2][1] to 3F800000 -> chk_err rises after that beat; row with no zero -> chk_err at its last_col.

Source files
------------

// File: rtl/submax_row_streamer_if.sv
// rtl/submax_row_streamer_if.sv - Y-matrix read port and element stream bundle for submax_row_streamer
interface submax_row_streamer_if #(
    parameter int DATA_W = 32,
    parameter int T_W    = 2
);
    logic              y_re;
    logic [T_W-1:0]    y_tq;
    logic [T_W-1:0]    y_tk;
    logic [DATA_W-1:0] y_rdata;
    logic              y_rvalid;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic [T_W-1:0]    o_tq;
    logic [T_W-1:0]    o_tk;
    logic              o_last_col;
    logic              o_last;

    modport master (
        output y_re, y_tq, y_tk,
        input  y_rdata, y_rvalid,
        output o_valid, o_data, o_tq, o_tk, o_last_col, o_last,
        input  o_ready
    );

    modport slave (
        input  y_re, y_tq, y_tk,
        output y_rdata, y_rvalid,
        input  o_valid, o_data, o_tq, o_tk, o_last_col, o_last,
        output o_ready
    );
endinterface

// File: rtl/submax_row_streamer.sv
// rtl/submax_row_streamer.sv - raster sweep of the submax Y matrix onto a tagged stream
// Optional row sanity checker (chk_err) enabled by SUBMAX_ROW_STREAMER_CHECK_EN.
module submax_row_streamer #(
    parameter int T      = 4,
    parameter int DATA_W = 32,
    parameter int T_W    = (T <= 1) ? 1 : $clog2(T),
    parameter int FIFO_D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [T_W:0]           n_len,
    output logic                   busy,
    output logic                   done,
`ifdef SUBMAX_ROW_STREAMER_CHECK_EN
    output logic                   chk_err,
`endif
    submax_row_streamer_if.master  bus
);
    localparam int PTR_W = (FIFO_D <= 2) ? 1 : $clog2(FIFO_D);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2 * T_W + 2;
    localparam logic [T_W:0] T_L = (T_W + 1)'(T);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [T_W:0]       r_n;
    logic [T_W-1:0]     r_rq_tq;
    logic [T_W-1:0]     r_rq_tk;
    logic [T_W-1:0]     r_rt_tq;
    logic [T_W-1:0]     r_rt_tk;
    logic [CNT_W-1:0]   r_outst;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [ENT_W-1:0]   r_mem [FIFO_D];

    logic [T_W:0]       w_n_clamp;
    logic [T_W:0]       w_nm1;
    logic               w_rq_tk_end;
    logic               w_rq_tq_end;
    logic               w_rt_lc;
    logic               w_rt_last;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_re;
    logic               w_credit;
    logic               w_start_acc;
    logic [CNT_W:0]     w_inflight;
    logic [ENT_W-1:0]   w_head;

    assign w_n_clamp   = (n_len > T_L) ? T_L : n_len;
    assign w_nm1       = r_n - 1'b1;
    assign w_rq_tk_end = ({1'b0, r_rq_tk} == w_nm1);
    assign w_rq_tq_end = ({1'b0, r_rq_tq} == w_nm1);
    assign w_rt_lc     = ({1'b0, r_rt_tk} == w_nm1);
    assign w_rt_last   = w_rt_lc && ({1'b0, r_rt_tq} == w_nm1);

    assign w_empty     = (r_cnt == '0);
    assign w_pop       = !w_empty && bus.o_ready;
    assign w_push      = bus.y_rvalid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_start_acc = (r_state == S_IDLE) && start;

    // A beat leaving this cycle frees its credit immediately, so a read
    // latency of FIFO_D-1 still sustains one element per cycle.
    assign w_inflight  = (CNT_W + 1)'(r_outst) + (CNT_W + 1)'(r_cnt) - (CNT_W + 1)'(w_pop);
    assign w_credit    = (w_inflight < (CNT_W + 1)'(FIFO_D));
    assign w_re        = (r_state == S_ISSUE) && w_credit;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_n_clamp == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_re && w_rq_tk_end && w_rq_tq_end) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((r_outst == '0) && (w_empty || ((r_cnt == CNT_W'(1)) && w_pop))) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_rq_tq  <= '0;
            r_rq_tk  <= '0;
            r_rt_tq  <= '0;
            r_rt_tk  <= '0;
            r_outst  <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_n     <= w_n_clamp;
                r_rq_tq <= '0;
                r_rq_tk <= '0;
                r_rt_tq <= '0;
                r_rt_tk <= '0;
            end
            if (w_re) begin
                if (w_rq_tk_end) begin
                    r_rq_tk <= '0;
                    r_rq_tq <= r_rq_tq + 1'b1;
                end else begin
                    r_rq_tk <= r_rq_tk + 1'b1;
                end
            end
            // Return-side tags replay the request order since responses arrive in order.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rt_lc) begin
                    r_rt_tk <= '0;
                    r_rt_tq <= r_rt_tq + 1'b1;
                end else begin
                    r_rt_tk <= r_rt_tk + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt   <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            r_outst <= r_outst + CNT_W'(w_re) - CNT_W'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.y_rdata, r_rt_tq, r_rt_tk, w_rt_lc, w_rt_last};
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.o_valid = !w_empty;
    assign {bus.o_data, bus.o_tq, bus.o_tk, bus.o_last_col, bus.o_last} = w_head;
    assign bus.y_re = w_re;
    assign bus.y_tq = w_re ? r_rq_tq : '0;
    assign bus.y_tk = w_re ? r_rq_tk : '0;

`ifdef SUBMAX_ROW_STREAMER_CHECK_EN
    logic              r_chk_err;
    logic              r_row_zero;
    logic [DATA_W-1:0] w_hd_data;
    logic              w_hd_lc;
    logic              w_hd_zero;
    logic              w_hd_nan;
    logic              w_hd_pos;

    assign w_hd_data = w_head[ENT_W-1 -: DATA_W];
    assign w_hd_lc   = w_head[1];
    assign w_hd_zero = (w_hd_data[30:0] == 31'd0);
    assign w_hd_nan  = (w_hd_data[30:23] == 8'hFF) && (w_hd_data[22:0] != 23'd0);
    assign w_hd_pos  = !w_hd_data[31] && !w_hd_zero && !w_hd_nan;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err  <= 1'b0;
            r_row_zero <= 1'b0;
        end else if (w_start_acc) begin
            r_chk_err  <= 1'b0;
            r_row_zero <= 1'b0;
        end else if (w_pop) begin
            if (w_hd_pos || (w_hd_lc && !(r_row_zero || w_hd_zero))) begin
                r_chk_err <= 1'b1;
            end
            r_row_zero <= w_hd_lc ? 1'b0 : (r_row_zero | w_hd_zero);
        end
    end

    assign chk_err = r_chk_err;
`endif
endmodule
